// File: rtl/unita_ricezione_rdy_ack_pkg.sv
// Shared definitions for the receive-side RDY/ACK unit: FSM state
// encodings, default geometry and statistics counter width.
// The optional statistics ports of the top level are enabled with the
// UNITA_RICEZIONE_STAT_EN macro.
package unita_ricezione_rdy_ack_pkg;

    // Two-state receive FSM, kept as plain constants for legacy tools.
    localparam logic [0:0] ATTESA = 1'b0;   // waiting for a pending message
    localparam logic [0:0] SCARTO = 1'b1;   // one cycle ignoring the stale rdy

    // Default message width and FIFO depth (depth must be a power of 2, >= 2).
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;

    // Width of the optional statistics counters.
    localparam int STAT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] incr_saturato(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/unita_ricezione_rdy_ack_coda.sv
// coda_messaggi: synchronous FIFO holding captured messages until the
// stack core accepts them. The head entry is kept in its own register so
// dato_out is a clean flop output that holds its last value when empty.
// A pop request on an empty queue and a push request on a full queue are
// both ignored.
module coda_messaggi
    import unita_ricezione_rdy_ack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_succ;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;
    logic             full, empty;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Next-state for pointers, occupancy and the registered head entry.
    always_comb begin
        push_ok  = push_i && !full;
        pop_ok   = pop_i && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_succ  = rd_ptr_q + AW'(1);
        head_d   = head_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_succ;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // After a pop the new head is the next stored entry, or the entry
        // being written right now if the queue held only one message.
        // A push into an empty queue becomes the head directly.
        if (pop_ok) begin
            head_d = (count_q > ONE_C) ? mem_q[rd_succ] : din_i;
        end else if (empty) begin
            head_d = din_i;
        end
        // Nothing left to present: keep showing the last value.
        if (count_d == '0) begin
            head_d = head_q;
        end
    end

    // Storage array; no reset so it maps onto plain RAM/LUT memory.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Control state; reset flushes the queue and clears the head.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign dout_o  = head_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign count_o = count_q;

endmodule

// File: rtl/unita_ricezione_rdy_ack.sv
// unita_ricezione_rdy_ack: receive side of a level-transition RDY/ACK
// channel. A pending message (rdy=1) is captured into a small FIFO, the
// detector is cleared with a one-cycle beta pulse and the sender is
// acknowledged by toggling ack_out. Buffered messages are offered to the
// stack core on a valid/ready interface.
// Optional statistics ports (n_ricevuti, n_stalli) are present only when
// UNITA_RICEZIONE_STAT_EN is defined.
module unita_ricezione_rdy_ack
    import unita_ricezione_rdy_ack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rdy,
    input  logic [WIDTH-1:0]         msg_in,
    output logic                     beta_out,
    output logic                     ack_out,
    output logic [WIDTH-1:0]         dato_out,
    output logic                     valido_out,
    input  logic                     pronto_in,
    output logic [$clog2(DEPTH):0]   count_out
`ifdef UNITA_RICEZIONE_STAT_EN
    ,
    output logic [STAT_W-1:0]        n_ricevuti,
    output logic [STAT_W-1:0]        n_stalli
`endif
);

    logic [0:0] state_q, state_d;
    logic       beta_q, beta_d;
    logic       ack_q, ack_d;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    // Capture decision and FSM next state. The FIFO full flag comes from
    // the registered count, so a pop this cycle cannot make room for a
    // push in the same cycle.
    always_comb begin
        push    = 1'b0;
        state_d = state_q;
        case (state_q)
            ATTESA: begin
                push    = rdy && !fifo_full;
                state_d = push ? SCARTO : ATTESA;
            end
            SCARTO: begin
                // rdy is still high from the message just taken: the
                // detector clears one edge after seeing beta.
                state_d = ATTESA;
            end
            default: state_d = ATTESA;
        endcase
        beta_d = push;
        ack_d  = ack_q ^ push;
    end

    // FSM, beta pulse and ACK level registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ATTESA;
            beta_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beta_q  <= beta_d;
            ack_q   <= ack_d;
        end
    end

    // The core only pops when there is something to take.
    assign pop = pronto_in && !fifo_empty;

    coda_messaggi #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_coda (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .din_i   (msg_in),
        .pop_i   (pop),
        .dout_o  (dato_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_out)
    );

    assign beta_out   = beta_q;
    assign ack_out    = ack_q;
    assign valido_out = !fifo_empty;

`ifdef UNITA_RICEZIONE_STAT_EN
    logic [STAT_W-1:0] n_ricevuti_q, n_ricevuti_d;
    logic [STAT_W-1:0] n_stalli_q, n_stalli_d;
    logic              stallo;

    // Captures wrap; stall cycles (waiting in ATTESA with a message
    // pending but no room) saturate.
    always_comb begin
        stallo       = (state_q == ATTESA) && rdy && fifo_full;
        n_ricevuti_d = push ? n_ricevuti_q + STAT_W'(1) : n_ricevuti_q;
        n_stalli_d   = stallo ? incr_saturato(n_stalli_q) : n_stalli_q;
    end

    // Statistics registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            n_ricevuti_q <= '0;
            n_stalli_q   <= '0;
        end else begin
            n_ricevuti_q <= n_ricevuti_d;
            n_stalli_q   <= n_stalli_d;
        end
    end

    assign n_ricevuti = n_ricevuti_q;
    assign n_stalli   = n_stalli_q;
`endif

endmodule

// File: tb/tb_unita_ricezione_rdy_ack.sv
// Directed testbench for unita_ricezione_rdy_ack (WIDTH=32, DEPTH=4).
// Includes a behavioural level-transition detector plus sender for the
// streaming scenarios. Statistics checks are compiled in only when
// UNITA_RICEZIONE_STAT_EN is defined.
module tb_unita_ricezione_rdy_ack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              rdy;
    logic [WIDTH-1:0]  msg_in;
    logic              beta_out;
    logic              ack_out;
    logic [WIDTH-1:0]  dato_out;
    logic              valido_out;
    logic              pronto_in = 1'b0;
    logic [2:0]        count_out;
`ifdef UNITA_RICEZIONE_STAT_EN
    logic [15:0]       n_ricevuti;
    logic [15:0]       n_stalli;
`endif

    int checks = 0;
    int errors = 0;
    logic exp_ack = 1'b0;

    // Direct drive or detector model.
    logic             model_en = 1'b0;
    logic             rdy_drv = 1'b0;
    logic [WIDTH-1:0] msg_drv = '0;

    // Detector/sender model state.
    logic [WIDTH-1:0] msgs [8];
    int               nmsg = 0;
    int               det_cnt = 0;
    int               sent = 0;
    int               acked = 0;
    int               acked_n;
    logic             ack_seen = 1'b0;
    logic             send_now;
    logic [WIDTH-1:0] mdl_msg = '0;

    always #5 clock = ~clock;

    assign rdy    = model_en ? (det_cnt != 0) : rdy_drv;
    assign msg_in = model_en ? mdl_msg : msg_drv;

    unita_ricezione_rdy_ack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rdy        (rdy),
        .msg_in     (msg_in),
        .beta_out   (beta_out),
        .ack_out    (ack_out),
        .dato_out   (dato_out),
        .valido_out (valido_out),
        .pronto_in  (pronto_in),
        .count_out  (count_out)
`ifdef UNITA_RICEZIONE_STAT_EN
        ,
        .n_ricevuti (n_ricevuti),
        .n_stalli   (n_stalli)
`endif
    );

    // Sender sends the next message once the previous one is acked.
    always_comb begin
        acked_n  = acked + ((ack_out !== ack_seen) ? 1 : 0);
        send_now = model_en && (sent == acked_n) && (sent < nmsg);
    end

    // Detector: counts sender transitions minus beta clears.
    always @(posedge clock) begin
        if (!reset_n || !model_en) begin
            det_cnt  <= 0;
            sent     <= 0;
            acked    <= 0;
            ack_seen <= ack_out;
        end else begin
            ack_seen <= ack_out;
            acked    <= acked_n;
            if (send_now) begin
                mdl_msg <= msgs[sent];
                sent    <= sent + 1;
            end
            det_cnt <= det_cnt + (send_now ? 1 : 0) - (beta_out ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rdy_drv = 1'b1; msg_drv = 32'h12345678; pronto_in = 1'b1;
        repeat (2) tick();
        checks++; if (beta_out !== 1'b0) begin errors++; $display("FAIL reset_beta: got %b expected 0", beta_out); end
        checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack_out); end
        checks++; if (valido_out !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b expected 0", valido_out); end
        checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        checks++; if (dato_out !== 32'h0) begin errors++; $display("FAIL reset_dato: got %h expected 0", dato_out); end
        rdy_drv = 1'b0; pronto_in = 1'b0; reset_n = 1'b1;
        tick();
        checks++; if (count_out !== 3'd0 || beta_out !== 1'b0) begin errors++; $display("FAIL idle: got count %0d beta %b expected 0 0", count_out, beta_out); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        rdy_drv = 1'b1; msg_drv = 32'hCAFE0001;
        tick();
        exp_ack = ~exp_ack;
        checks++; if (beta_out !== 1'b1) begin errors++; $display("FAIL single_beta: got %b expected 1", beta_out); end
        checks++; if (ack_out !== exp_ack) begin errors++; $display("FAIL single_ack: got %b expected %b", ack_out, exp_ack); end
        checks++; if (valido_out !== 1'b1) begin errors++; $display("FAIL single_valido: got %b expected 1", valido_out); end
        checks++; if (dato_out !== 32'hCAFE0001) begin errors++; $display("FAIL single_dato: got %h expected cafe0001", dato_out); end
        checks++; if (count_out !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count_out); end
        // rdy still stale high: must be ignored
        tick();
        checks++; if (beta_out !== 1'b0) begin errors++; $display("FAIL single_beta_pulse: got %b expected 0", beta_out); end
        checks++; if (count_out !== 3'd1) begin errors++; $display("FAIL single_stale_rdy: got count %0d expected 1", count_out); end
        checks++; if (ack_out !== exp_ack) begin errors++; $display("FAIL single_ack_hold: got %b expected %b", ack_out, exp_ack); end
        rdy_drv = 1'b0; pronto_in = 1'b1;
        tick();
        pronto_in = 1'b0;
        checks++; if (valido_out !== 1'b0 || count_out !== 3'd0) begin errors++; $display("FAIL single_pop: got valido %b count %0d expected 0 0", valido_out, count_out); end
        checks++; if (dato_out !== 32'hCAFE0001) begin errors++; $display("FAIL single_dato_hold: got %h expected cafe0001", dato_out); end
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        int cap[$];
        logic [WIDTH-1:0] outs[$];
        int toggles = 0;
        logic last_ack;
        msgs[0] = 32'hA0A0_0000; msgs[1] = 32'hA1A1_1111; msgs[2] = 32'hA2A2_2222;
        nmsg = 3; pronto_in = 1'b1; model_en = 1'b1;
        last_ack = ack_out;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (beta_out) cap.push_back(c);
            if (ack_out !== last_ack) toggles++;
            last_ack = ack_out;
            if (valido_out && pronto_in) outs.push_back(dato_out);
        end
        exp_ack = exp_ack ^ 1'b1 ^ 1'b1 ^ 1'b1;
        checks++; if (toggles != 3) begin errors++; $display("FAIL b2b_toggles: got %0d expected 3", toggles); end
        checks++; if (ack_out !== exp_ack) begin errors++; $display("FAIL b2b_ack: got %b expected %b", ack_out, exp_ack); end
        checks++;
        if (cap.size() != 3) begin
            errors++; $display("FAIL b2b_captures: got %0d expected 3", cap.size());
        end else if (cap[1] - cap[0] != 2 || cap[2] - cap[1] != 2) begin
            errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 2,2", cap[1] - cap[0], cap[2] - cap[1]);
        end
        checks++;
        if (outs.size() != 3) begin
            errors++; $display("FAIL b2b_outputs: got %0d expected 3", outs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (outs[i] !== msgs[i]) begin
                    errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, outs[i], msgs[i]);
                end
            end
        end
        checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", count_out); end
        model_en = 1'b0; pronto_in = 1'b0;
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_full();
        int betas = 0;
        int toggles = 0;
        int stalls = 0;
        logic last_ack;
        for (int i = 0; i < 5; i++) msgs[i] = 32'hB000_0000 + i;
        nmsg = 5; pronto_in = 1'b0; model_en = 1'b1;
        last_ack = ack_out;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (beta_out) betas++;
            if (ack_out !== last_ack) toggles++;
            last_ack = ack_out;
            if (rdy && count_out == 3'd4 && !beta_out) stalls++;
        end
        checks++; if (count_out !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count_out); end
        checks++; if (betas != 4 || toggles != 4) begin errors++; $display("FAIL full_acks: got beta %0d toggles %0d expected 4 4", betas, toggles); end
        checks++; if (beta_out !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL full_5th_pending: got beta %b rdy %b expected 0 1", beta_out, rdy); end
        checks++; if (stalls != 8) begin errors++; $display("FAIL full_stall_cycles: got %0d expected 8", stalls); end
        checks++; if (dato_out !== 32'hB000_0000) begin errors++; $display("FAIL full_head: got %h expected b0000000", dato_out); end
        pronto_in = 1'b1;
        tick();
        pronto_in = 1'b0;
        checks++; if (count_out !== 3'd3 || beta_out !== 1'b0) begin errors++; $display("FAIL full_pop_no_push: got count %0d beta %b expected 3 0", count_out, beta_out); end
        checks++; if (dato_out !== 32'hB000_0001) begin errors++; $display("FAIL full_pop_head: got %h expected b0000001", dato_out); end
        tick();
        exp_ack = exp_ack ^ 1'b1;
        checks++; if (beta_out !== 1'b1 || count_out !== 3'd4) begin errors++; $display("FAIL full_resume: got beta %b count %0d expected 1 4", beta_out, count_out); end
        checks++; if (ack_out !== exp_ack) begin errors++; $display("FAIL full_ack: got %b expected %b", ack_out, exp_ack); end
`ifdef UNITA_RICEZIONE_STAT_EN
        checks++; if (n_stalli !== 16'd8) begin errors++; $display("FAIL stat_stalli: got %0d expected 8", n_stalli); end
        checks++; if (n_ricevuti !== 16'd9) begin errors++; $display("FAIL stat_ricevuti: got %0d expected 9", n_ricevuti); end
`endif
        tick();
        tick();
        model_en = 1'b0;
        tick();
        $display("test_full done");
    endtask

    task automatic test_push_pop();
        pronto_in = 1'b1;
        tick();
        tick();
        pronto_in = 1'b0;
        checks++; if (count_out !== 3'd2 || dato_out !== 32'hB000_0003) begin errors++; $display("FAIL pp_setup: got count %0d dato %h expected 2 b0000003", count_out, dato_out); end
        rdy_drv = 1'b1; msg_drv = 32'hC0C0_C0C0; pronto_in = 1'b1;
        tick();
        exp_ack = exp_ack ^ 1'b1;
        checks++; if (count_out !== 3'd2) begin errors++; $display("FAIL pp_count: got %0d expected 2", count_out); end
        checks++; if (dato_out !== 32'hB000_0004) begin errors++; $display("FAIL pp_head: got %h expected b0000004", dato_out); end
        checks++; if (beta_out !== 1'b1 || ack_out !== exp_ack) begin errors++; $display("FAIL pp_ack: got beta %b ack %b expected 1 %b", beta_out, ack_out, exp_ack); end
        rdy_drv = 1'b0; pronto_in = 1'b0;
        tick();
        pronto_in = 1'b1;
        tick();
        pronto_in = 1'b0;
        checks++; if (count_out !== 3'd1 || dato_out !== 32'hC0C0_C0C0) begin errors++; $display("FAIL pp_tail: got count %0d dato %h expected 1 c0c0c0c0", count_out, dato_out); end
        $display("test_push_pop done");
    endtask

    task automatic test_reset_mid();
        rdy_drv = 1'b1; msg_drv = 32'hD000_0000;
        tick();
        rdy_drv = 1'b0; pronto_in = 1'b1;
        tick();
        pronto_in = 1'b0; rdy_drv = 1'b1; msg_drv = 32'hD000_0001;
        tick();
        rdy_drv = 1'b0;
        tick();
        rdy_drv = 1'b1; msg_drv = 32'hD000_0002;
        tick();
        rdy_drv = 1'b0;
        tick();
        exp_ack = exp_ack ^ 1'b1 ^ 1'b1 ^ 1'b1;
        checks++; if (count_out !== 3'd3 || ack_out !== exp_ack) begin errors++; $display("FAIL mid_setup: got count %0d ack %b expected 3 %b", count_out, ack_out, exp_ack); end
`ifdef UNITA_RICEZIONE_STAT_EN
        checks++; if (n_ricevuti !== 16'd13) begin errors++; $display("FAIL stat_ricevuti_pre: got %0d expected 13", n_ricevuti); end
`endif
        reset_n = 1'b0;
        tick();
        checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count_out); end
        checks++; if (valido_out !== 1'b0) begin errors++; $display("FAIL mid_valido: got %b expected 0", valido_out); end
        checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b expected 0", ack_out); end
        checks++; if (dato_out !== 32'h0) begin errors++; $display("FAIL mid_dato: got %h expected 0", dato_out); end
`ifdef UNITA_RICEZIONE_STAT_EN
        checks++; if (n_ricevuti !== 16'd0 || n_stalli !== 16'd0) begin errors++; $display("FAIL stat_reset: got %0d %0d expected 0 0", n_ricevuti, n_stalli); end
`endif
        reset_n = 1'b1;
        tick();
        exp_ack = 1'b0;
        $display("test_reset_mid done");
    endtask

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
